// File: rtl/align_monitor.sv
// align_monitor: training-pattern checker for the PLL phase controller.
// Each accepted word is classified as GOOD, ROT (rotated pattern) or BERR over
// a window of WIN_LEN valid words. A one-cycle status_valid pulse delivers
// align_status = {rotation error, bit error}. Lock loss, stop, or any phase
// change restarts the measurement so the controller never sees a stale result.
module align_monitor #(
  parameter int unsigned     DW         = 8,
  parameter logic [DW-1:0]   PATTERN    = 8'b00001111,
  parameter int unsigned     SETTLE     = 16,
  parameter int unsigned     WIN_LEN    = 64,
  parameter int unsigned     ERR_THRESH = 0
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           lock,
  input  logic [3:0]                     phase,
  input  logic                           stop,
  input  logic                           data_valid,
  input  logic [DW-1:0]                  data,
  output logic [1:0]                     align_status,
  output logic                           status_valid,
  output logic [$clog2(DW)-1:0]          rot_amt,
  output logic [$clog2(WIN_LEN+1)-1:0]   err_cnt
);

  localparam int unsigned RW = $clog2(DW);
  localparam int unsigned CW = $clog2(WIN_LEN + 1);
  localparam int unsigned SW = $clog2(SETTLE + 1);

  localparam logic [CW-1:0] WIN_LAST    = CW'(WIN_LEN - 1);
  localparam logic [CW-1:0] WIN_FULL    = CW'(WIN_LEN);
  localparam logic [CW-1:0] THRESH      = CW'(ERR_THRESH);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_MEASURE,
    S_REPORT
  } state_t;

  state_t state, next_state;

  logic          lock_m, lock_s;
  logic [3:0]    phase_q;
  logic [SW-1:0] settle_cnt;
  logic [CW-1:0] win_cnt, rot_cnt, berr_cnt;

  logic          restart, accept, last_word, settle_done;
  logic          is_good, is_rot;
  logic [RW-1:0] rot_hit;

  function automatic logic [DW-1:0] rotl(input logic [DW-1:0] v, input int unsigned r);
    return (v << r) | (v >> (DW - r));
  endfunction

  // Two-flop synchronizer for the asynchronous PLL lock, plus phase history.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lock_m  <= 1'b0;
      lock_s  <= 1'b0;
      phase_q <= '0;
    end else begin
      lock_m  <= lock;
      lock_s  <= lock_m;
      phase_q <= phase;
    end
  end

  // Word classification against the pattern and each of its rotations.
  always_comb begin
    is_good = (data == PATTERN);
    is_rot  = 1'b0;
    rot_hit = '0;
    for (int unsigned r = 1; r < DW; r++) begin
      if (data == rotl(PATTERN, r)) begin
        is_rot  = 1'b1;
        rot_hit = RW'(r);
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= next_state;
  end

  // Next-state logic; a restart overrides every other transition.
  always_comb begin
    next_state  = state;
    restart     = (state != S_IDLE) && (!lock_s || stop || (phase != phase_q));
    accept      = (state == S_MEASURE) && data_valid && !restart;
    last_word   = accept && (win_cnt == WIN_LAST);
    settle_done = (state == S_SETTLE) && (settle_cnt == SETTLE_LAST);
    if (restart) begin
      next_state = lock_s ? S_SETTLE : S_IDLE;
    end else begin
      case (state)
        S_IDLE:    if (lock_s) next_state = S_SETTLE;
        S_SETTLE:  if (settle_done) next_state = S_MEASURE;
        S_MEASURE: if (last_word) next_state = S_REPORT;
        S_REPORT:  next_state = S_MEASURE;
        default:   next_state = S_IDLE;
      endcase
    end
  end

  // Window counters and registered status outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      settle_cnt   <= '0;
      win_cnt      <= '0;
      rot_cnt      <= '0;
      berr_cnt     <= '0;
      align_status <= 2'b11;
      status_valid <= 1'b0;
      rot_amt      <= '0;
      err_cnt      <= '0;
    end else begin
      status_valid <= 1'b0;
      if (restart) begin
        align_status <= 2'b11;
        settle_cnt   <= '0;
        win_cnt      <= '0;
        rot_cnt      <= '0;
        berr_cnt     <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            align_status <= 2'b11;
            settle_cnt   <= '0;
          end
          S_SETTLE: begin
            if (settle_done) begin
              settle_cnt <= '0;
              win_cnt    <= '0;
              rot_cnt    <= '0;
              berr_cnt   <= '0;
            end else begin
              settle_cnt <= settle_cnt + 1'b1;
            end
          end
          S_MEASURE: begin
            if (accept) begin
              win_cnt <= win_cnt + 1'b1;
              if (is_rot) begin
                rot_amt <= rot_hit;
                if (rot_cnt != WIN_FULL) rot_cnt <= rot_cnt + 1'b1;
              end else if (!is_good) begin
                if (berr_cnt != WIN_FULL) berr_cnt <= berr_cnt + 1'b1;
              end
            end
          end
          S_REPORT: begin
            align_status <= {(rot_cnt > THRESH), (berr_cnt > THRESH)};
            err_cnt      <= berr_cnt;
            status_valid <= 1'b1;
            win_cnt      <= '0;
            rot_cnt      <= '0;
            berr_cnt     <= '0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_align_monitor.sv
// Directed testbench for align_monitor: three instances share stimulus and
// differ only in ERR_THRESH (0, 4, 5).
module tb_align_monitor;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       lock = 1'b0;
  logic [3:0] phase = 4'd0;
  logic       stop = 1'b0;
  logic       data_valid = 1'b0;
  logic [7:0] data = 8'h00;

  logic [1:0] st0, st4, st5;
  logic       sv0, sv4, sv5;
  logic [2:0] ra0, ra4, ra5;
  logic [6:0] ec0, ec4, ec5;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  align_monitor dut (
    .clk(clk), .reset_n(reset_n), .lock(lock), .phase(phase), .stop(stop),
    .data_valid(data_valid), .data(data), .align_status(st0),
    .status_valid(sv0), .rot_amt(ra0), .err_cnt(ec0)
  );

  align_monitor #(.ERR_THRESH(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .lock(lock), .phase(phase), .stop(stop),
    .data_valid(data_valid), .data(data), .align_status(st4),
    .status_valid(sv4), .rot_amt(ra4), .err_cnt(ec4)
  );

  align_monitor #(.ERR_THRESH(5)) dut5 (
    .clk(clk), .reset_n(reset_n), .lock(lock), .phase(phase), .stop(stop),
    .data_valid(data_valid), .data(data), .align_status(st5),
    .status_valid(sv5), .rot_amt(ra5), .err_cnt(ec5)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Edges until the next status_valid pulse on the default instance; -1 on timeout.
  task automatic wait_pulse(input int max, output int n);
    int i;
    i = 0;
    n = -1;
    while (n < 0 && i < max) begin
      tick();
      i++;
      if (sv0 === 1'b1) n = i;
    end
  endtask

  task automatic test_reset();
    int bad;
    reset_n = 1'b0; lock = 1'b0; data_valid = 1'b1;
    repeat (3) begin data = 8'($urandom); tick(); end
    checks++; if (st0 !== 2'b11) begin errors++; $display("FAIL reset_status got %b want 11", st0); end
    checks++; if (sv0 !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", sv0); end
    checks++; if (ra0 !== 3'd0) begin errors++; $display("FAIL reset_rot_amt got %0d want 0", ra0); end
    checks++; if (ec0 !== 7'd0) begin errors++; $display("FAIL reset_err_cnt got %0d want 0", ec0); end
    reset_n = 1'b1;
    bad = 0;
    repeat (500) begin
      data = 8'($urandom);
      tick();
      if (st0 !== 2'b11 || sv0 !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL unlocked_idle bad_cycles got %0d want 0", bad); end
  endtask

  task automatic test_good();
    int n;
    lock = 1'b1; data = 8'h0F; data_valid = 1'b1;
    wait_pulse(200, n);
    checks++; if (n !== 84) begin errors++; $display("FAIL first_pulse_latency got %0d want 84", n); end
    checks++; if (st0 !== 2'b00) begin errors++; $display("FAIL good_status got %b want 00", st0); end
    checks++; if (ec0 !== 7'd0) begin errors++; $display("FAIL good_err_cnt got %0d want 0", ec0); end
    wait_pulse(100, n);
    checks++; if (n !== 65) begin errors++; $display("FAIL pulse_period got %0d want 65", n); end
  endtask

  task automatic test_rot();
    int n;
    data = 8'h78;
    tick();
    checks++; if (sv0 !== 1'b0) begin errors++; $display("FAIL pulse_width got %b want 0", sv0); end
    wait_pulse(100, n);
    checks++; if (n !== 64) begin errors++; $display("FAIL rot_pulse got %0d want 64", n); end
    checks++; if (st0 !== 2'b10) begin errors++; $display("FAIL rot_status got %b want 10", st0); end
    checks++; if (ra0 !== 3'd3) begin errors++; $display("FAIL rot_amt got %0d want 3", ra0); end
    checks++; if (ec0 !== 7'd0) begin errors++; $display("FAIL rot_err_cnt got %0d want 0", ec0); end
    checks++; if (st4 !== 2'b10) begin errors++; $display("FAIL rot_status_t4 got %b want 10", st4); end
  endtask

  task automatic test_berr();
    for (int i = 0; i < 64; i++) begin
      data = (i == 3 || i == 10 || i == 20 || i == 40 || i == 63) ? 8'h0E : 8'h0F;
      tick();
    end
    data = 8'h0F;
    tick();
    checks++; if (sv0 !== 1'b1) begin errors++; $display("FAIL berr_pulse got %b want 1", sv0); end
    checks++; if (st0 !== 2'b01) begin errors++; $display("FAIL berr_status_t0 got %b want 01", st0); end
    checks++; if (ec0 !== 7'd5) begin errors++; $display("FAIL berr_cnt_t0 got %0d want 5", ec0); end
    checks++; if (st4 !== 2'b01) begin errors++; $display("FAIL berr_status_t4 got %b want 01", st4); end
    checks++; if (ec4 !== 7'd5) begin errors++; $display("FAIL berr_cnt_t4 got %0d want 5", ec4); end
    checks++; if (st5 !== 2'b00) begin errors++; $display("FAIL berr_status_t5 got %b want 00", st5); end
    checks++; if (ec5 !== 7'd5) begin errors++; $display("FAIL berr_cnt_t5 got %0d want 5", ec5); end
    checks++; if (ra0 !== 3'd3) begin errors++; $display("FAIL berr_rot_amt_kept got %0d want 3", ra0); end
  endtask

  task automatic test_phase();
    int n;
    data = 8'h0F;
    repeat (40) tick();
    phase = 4'd1;
    tick();
    checks++; if (st0 !== 2'b11) begin errors++; $display("FAIL phase_restart_status got %b want 11", st0); end
    checks++; if (sv0 !== 1'b0) begin errors++; $display("FAIL phase_restart_valid got %b want 0", sv0); end
    wait_pulse(200, n);
    checks++; if (n !== 81) begin errors++; $display("FAIL phase_pulse_latency got %0d want 81", n); end
    checks++; if (st0 !== 2'b00) begin errors++; $display("FAIL phase_status got %b want 00", st0); end
  endtask

  task automatic test_stop();
    int n, bad;
    data = 8'h0F;
    repeat (20) tick();
    stop = 1'b1; data = 8'h0E; data_valid = 1'b1;
    bad = 0;
    repeat (12) begin
      tick();
      if (st0 !== 2'b11 || sv0 !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL stop_hold bad_cycles got %0d want 0", bad); end
    stop = 1'b0;
    n = -1;
    for (int k = 1; k <= 200 && n < 0; k++) begin
      data_valid = (k % 2) == 1;
      data = (k <= 16) ? 8'h0E : 8'h0F;
      tick();
      if (sv0 === 1'b1) n = k;
    end
    data_valid = 1'b1; data = 8'h0F;
    checks++; if (n !== 144) begin errors++; $display("FAIL stop_window_latency got %0d want 144", n); end
    checks++; if (st0 !== 2'b00) begin errors++; $display("FAIL stop_status got %b want 00", st0); end
    checks++; if (ec0 !== 7'd0) begin errors++; $display("FAIL stop_err_cnt got %0d want 0", ec0); end
  endtask

  task automatic test_back_to_back();
    int n;
    data = 8'h0F; data_valid = 1'b1;
    repeat (64) tick();
    phase = 4'd2;
    tick();
    checks++; if (sv0 !== 1'b0) begin errors++; $display("FAIL report_restart_valid got %b want 0", sv0); end
    checks++; if (st0 !== 2'b11) begin errors++; $display("FAIL report_restart_status got %b want 11", st0); end
    wait_pulse(200, n);
    checks++; if (n !== 81) begin errors++; $display("FAIL report_restart_latency got %0d want 81", n); end
  endtask

  task automatic test_lock_drop();
    int bad;
    lock = 1'b0;
    tick(); tick();
    checks++; if (st0 !== 2'b00) begin errors++; $display("FAIL lock_sync_delay got %b want 00", st0); end
    tick();
    checks++; if (st0 !== 2'b11) begin errors++; $display("FAIL lock_drop_status got %b want 11", st0); end
    bad = 0;
    repeat (150) begin
      tick();
      if (st0 !== 2'b11 || sv0 !== 1'b0) bad++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL lock_low_idle bad_cycles got %0d want 0", bad); end
  endtask

  task automatic test_mixed_and_reset();
    int n;
    lock = 1'b1; data_valid = 1'b1;
    n = -1;
    for (int k = 1; k <= 200 && n < 0; k++) begin
      data = (k % 2 == 1) ? 8'h87 : 8'h0E;
      tick();
      if (sv0 === 1'b1) n = k;
    end
    checks++; if (n !== 84) begin errors++; $display("FAIL mixed_latency got %0d want 84", n); end
    checks++; if (st0 !== 2'b11) begin errors++; $display("FAIL mixed_status got %b want 11", st0); end
    checks++; if (ec0 !== 7'd32) begin errors++; $display("FAIL mixed_err_cnt got %0d want 32", ec0); end
    checks++; if (ra0 !== 3'd7) begin errors++; $display("FAIL mixed_rot_amt got %0d want 7", ra0); end
    data = 8'h0F;
    repeat (30) tick();
    reset_n = 1'b0;
    tick();
    checks++; if (st0 !== 2'b11) begin errors++; $display("FAIL midreset_status got %b want 11", st0); end
    checks++; if (sv0 !== 1'b0) begin errors++; $display("FAIL midreset_valid got %b want 0", sv0); end
    checks++; if (ra0 !== 3'd0) begin errors++; $display("FAIL midreset_rot_amt got %0d want 0", ra0); end
    checks++; if (ec0 !== 7'd0) begin errors++; $display("FAIL midreset_err_cnt got %0d want 0", ec0); end
    reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_good();
    test_rot();
    test_berr();
    test_phase();
    test_stop();
    test_back_to_back();
    test_lock_drop();
    test_mixed_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout got running want finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/align_monitor.md
Name: align_monitor

Overview:
- Training-pattern checker that feeds the PLL phase controller. It classifies each deserialized word from the gearbox against a fixed training pattern over a measurement window and produces the 2-bit align_status the controller consumes.
- Bit 0 reports bit-level sampling errors and drives the phase sweep. Bit 1 reports word misalignment and drives datapath reset.
- The block restarts its measurement whenever the controller rotates phase, asserts stop, or lock drops, so the controller never samples a stale result.

Parameters:
- DW, 8, data word width.
- PATTERN, 8'b00001111, training word. It must differ from every non-zero rotation of itself.
- SETTLE, 16, cycles ignored after any restart before counting begins.
- WIN_LEN, 64, valid words per measurement window. SETTLE+WIN_LEN+4 must be less than 255.
- ERR_THRESH, 0, a window flags a bit when its count exceeds this value.

Ports:
- clk  in  1  Single clock, shared with the phase controller.
- reset_n  in  1  Synchronous, active-low reset.
- lock  in  1  PLL lock, asynchronous; double-registered internally.
- phase  in  4  Phase select from the controller; any change triggers a restart.
- stop  in  1  Datapath-reset window; words are ignored and a restart is forced.
- data_valid  in  1  Qualifies data.
- data  in  DW  Deserialized word.
- align_status  out  2  [0] bit errors, [1] rotation error; 1 = bad.
- status_valid  out  1  One-cycle pulse when align_status is updated from a completed window.
- rot_amt  out  clog2(DW)  Rotation r of the last rotated word, where data == PATTERN rotated left by r.
- err_cnt  out  clog2(WIN_LEN+1)  Bit-error count of the last completed window.

Behaviour:
- Reset (reset_n low at a clk edge) sets:
  - state IDLE, align_status 2'b11, status_valid 0, rot_amt 0, err_cnt 0;
  - all counters 0, lock synchronizer 0, phase_q 0.
- Word classification is combinational, for an accepted word (data_valid high in MEASURE):
  - GOOD if data == PATTERN;
  - ROT if data equals a rotate-left of PATTERN by r, 1 <= r <= DW-1;
  - otherwise BERR.
- Counters:
  - win_cnt counts accepted words.
  - rot_cnt and berr_cnt count their classes; both saturate at WIN_LEN.
  - On each ROT word, rot_amt <= r.
- Restart condition = lock_s == 0, or stop == 1, or phase != phase_q. phase_q is registered every cycle.
- State machine:
  - IDLE: align_status held at 2'b11. Go to SETTLE when lock_s == 1.
  - SETTLE: settle_cnt counts 0..SETTLE-1 every cycle, regardless of data_valid. Go to MEASURE after SETTLE cycles, with win_cnt, rot_cnt and berr_cnt cleared.
  - MEASURE: accept words. Go to REPORT on the edge that accepts word number WIN_LEN.
  - REPORT, one cycle:
    - align_status[0] <= berr_cnt > ERR_THRESH;
    - align_status[1] <= rot_cnt > ERR_THRESH;
    - err_cnt <= berr_cnt; status_valid <= 1;
    - counters cleared; go to MEASURE.
  - Windows then repeat back-to-back with no re-settle.
- Restart handling (checked in any state except IDLE, with priority over all transitions):
  - align_status <= 2'b11, status_valid <= 0, counters cleared.
  - If lock_s == 0, go to IDLE; otherwise go to SETTLE.
  - stop held high keeps the block in SETTLE with settle_cnt at 0.
- Latency:
  - The window result is visible one cycle after the edge that accepted the last word.
  - After a phase change with continuous data_valid, the first status_valid arrives exactly SETTLE+WIN_LEN+1 cycles after the edge that registers the new phase.
- status_valid is high only in the cycle following REPORT. It is never high during IDLE or SETTLE.
- data_valid low is not an error: MEASURE simply waits.
- Simultaneous restart and window completion: restart wins, no status_valid, align_status = 11.
- BERR and ROT in the same window both flag; bits are independent.
- reset_n low mid-window discards the window; outputs return to their reset values the next edge.

Test Plan:
- reset_n low 3 cycles, lock 0, random data -> align_status=2'b11, status_valid=0 for 500 cycles.
- lock 1, data=8'h0F every cycle -> status_valid pulse at cycle SETTLE+WIN_LEN+1 after SETTLE entry (81); align_status=2'b00, err_cnt=0; pulse repeats every 65 cycles.
- lock 1, data=8'h78 (PATTERN rotated left by 3) -> align_status=2'b10, rot_amt=3, err_cnt=0.
- lock 1, 8'h0F with 8'h0E injected on 5 of 64 words, ERR_THRESH=4 -> align_status=2'b01, err_cnt=5. Repeat with ERR_THRESH=5 -> 2'b00.
- phase changed 0->1 at word 40 of a window -> align_status=2'b11 next cycle; no pulse for that window; next pulse 81 cycles after the phase edge.
- stop high 12 cycles mid-window, then data_valid toggling 50% -> restart to SETTLE. The window completes after 64 valid words (~128 cycles), and no word seen while stop was high is counted.
